sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO with integrated storage, pointer and occupancy tracking, and registered read data. It is the synchronous-domain counterpart of the async FIFO storage path and is used wherever AHB-side and APB-side logic share a clock. Over the dual-clock storage array it adds an occupancy count, programmable almost-full/almost-empty flags, a read-valid strobe, sticky overflow/underflow error flags and a synchronous flush.

## Interface
Parameters:
- DSIZE, 6, data width in bits.
- ASIZE, 4, address width; DEPTH = 1 << ASIZE, derived and not overridable.
- AFULL_TH, 14, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of pointers, count and flags.
- wclk_en  in  1  write request.
- wdata  in  DSIZE  write data.
- rclk_en  in  1  read request.
- rdata  out  DSIZE  registered read data.
- rvalid  out  1  rdata holds a newly popped word this cycle.
- wfull  out  1  count == DEPTH.
- rempty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write requested while wfull.
- underflow  out  1  sticky: read requested while rempty.

## Operation
- Write accepted (wr_ok) iff wclk_en && !wfull. mem[wptr] <= wdata, and wptr increments.
- Read accepted (rd_ok) iff rclk_en && !rempty. rdata <= mem[rptr], rptr increments, and rvalid <= 1.
- If no read is accepted, rvalid <= 0 and rdata holds its last value. rdata is never zeroed except by reset.
- wptr and rptr are ASIZE+1 bits and wrap naturally modulo 2*DEPTH. Storage is indexed by the low ASIZE bits.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged if both or neither.
- Simultaneous read and write:
  - When not full and not empty, both are accepted and count is unchanged.
  - When full, the read is accepted, the write is dropped and overflow is set.
  - When empty, the write is accepted and the read is rejected. underflow is set, rvalid stays 0, and no same-cycle bypass occurs.
- Dropped accesses never modify memory or pointers.
- Status flags (wfull, rempty, almost_*) are decoded from the registered count, so they reflect state after the last edge.
- Dropped accesses set overflow and underflow. Both stay set until rst or flush.
- flush:
  - On the next edge, wptr, rptr, count, rvalid, overflow and underflow go to 0.
  - Memory contents and rdata are retained.
  - flush overrides any same-cycle wclk_en/rclk_en, and both are ignored that cycle.

## Timing
- Reset values: rdata=0, rvalid=0, count=0, rempty=1, wfull=0, almost_empty=1, almost_full=0 (for AFULL_TH>=1), overflow=0, underflow=0, pointers=0. Memory is not reset.
- rst mid-operation: everything above is restored on the next edge, and pending requests are ignored. rst has priority over flush.
- Write-to-visible latency: a write accepted at edge N clears rempty after edge N. A read request at edge N+1 returns data at edge N+1, with rvalid high for the cycle after N+1.
- Read latency is 1 cycle from the accepting edge to rdata/rvalid.
- Throughput: 1 write and 1 read per cycle sustained.
- A full FIFO with only a read at edge N deasserts wfull after N. A write in the same cycle as that read is still dropped.

## Structure
- Shared package fifo_pkg holds:
  - default DSIZE/ASIZE/threshold constants;
  - a function to compute the pointer width;
  - the write/read accept-condition encoding for reuse by the async FIFO.
- One sub-module, sync_fifo_ram: DEPTH x DSIZE array with one write port and one registered read port, no reset, enables only. Top level holds pointers, count, flags and error logic.

## Test plan
- Reset, then 16 writes of 0x01..0x10 with no reads: wfull=1 after the 16th edge, count=16, almost_full from count 14. A 17th write sets overflow and does not corrupt mem[0].
- Then 16 reads: rdata = 0x01..0x10 in order, rvalid=1 each cycle, rempty=1 after the last. A 17th read sets underflow and leaves rdata=0x10 with rvalid=0.
- Wrap-around: 40 interleaved write/read pairs at count=3. Data order is preserved across the pointer MSB wrap and count stays 3.
- Simultaneous read+write at full and at empty: the full case gives count 15 and overflow=1; the empty case gives count 1, underflow=1 and rvalid=0.
- flush at count=9 with wclk_en=rclk_en=1: next cycle count=0, rempty=1, overflow=underflow=0, and rdata unchanged.
- rst asserted mid-burst at count=7 with a pending read: the next edge gives all reset values, rvalid=0 and rdata=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, pointer width helper and the
// request-accept encoding reused by both the sync and async FIFO flavours.
package fifo_pkg;

  localparam int DEF_DSIZE     = 6;
  localparam int DEF_ASIZE     = 4;
  localparam int DEF_AFULL_TH  = 14;
  localparam int DEF_AEMPTY_TH = 2;

  // Outcome of a single write or read request in one cycle.
  typedef enum logic [1:0] {
    ACC_IDLE = 2'b00,
    ACC_OK   = 2'b01,
    ACC_DROP = 2'b10
  } acc_e;

  // One extra bit beyond the address distinguishes full from empty.
  function automatic int ptr_width(input int asize);
    return asize + 1;
  endfunction

  function automatic acc_e access(input logic req, input logic blocked);
    if (!req)
      return ACC_IDLE;
    else if (blocked)
      return ACC_DROP;
    else
      return ACC_OK;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DSIZE storage with one write port and one registered read port.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, threshold flags, sticky errors and
// flush around a reset-free storage array with registered read data.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wclk_en,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rclk_en,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int PW    = ptr_width(ASIZE);

  localparam logic [PW-1:0] FULL_CNT   = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_CNT  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_CNT = PW'(AEMPTY_TH);

  logic [PW-1:0]    wptr, rptr;
  logic [DSIZE-1:0] ram_q;
  logic             rd_seen;
  logic             wr_ok, rd_ok;
  acc_e             wr_acc, rd_acc;

  assign wfull        = (count == FULL_CNT);
  assign rempty       = (count == '0);
  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

  assign wr_acc = access(wclk_en, wfull);
  assign rd_acc = access(rclk_en, rempty);

  // rst and flush swallow any request in their cycle, including the memory write.
  assign wr_ok = (wr_acc == ACC_OK) && !rst && !flush;
  assign rd_ok = (rd_acc == ACC_OK) && !rst && !flush;

  sync_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (ram_q)
  );

  // The RAM read register is not reset; rdata reads as zero until the first pop after rst.
  assign rdata = rd_seen ? ram_q : '0;

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_seen   <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (rd_ok)
        rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rvalid <= rd_ok;
      if (rd_ok)
        rd_seen <= 1'b1;
      if (wr_acc == ACC_DROP)
        overflow <= 1'b1;
      if (rd_acc == ACC_DROP)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed vector table for the FIFO corner cases, then randomized traffic
// checked against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, flush, wclk_en, rclk_en;
  logic [5:0] wdata;
  logic [5:0] rdata;
  logic       rvalid, wfull, rempty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wclk_en      (wclk_en),
    .wdata        (wdata),
    .rclk_en      (rclk_en),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  typedef struct {
    logic       rst, flush, wen;
    logic [5:0] wd;
    logic       ren;
    int         cnt;
    logic       rv;
    logic [5:0] rd;
    logic       of, uf;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a plain queue of words plus the output registers.
  logic [5:0] mq[$];
  logic [5:0] m_rdata;
  logic       m_rvalid, m_of, m_uf;

  task automatic add(input logic r, f, we, input logic [5:0] wd, input logic re,
                     input int cnt, input logic rv, input logic [5:0] rd,
                     input logic of, uf);
    vec_t v;
    v.rst = r; v.flush = f; v.wen = we; v.wd = wd; v.ren = re;
    v.cnt = cnt; v.rv = rv; v.rd = rd; v.of = of; v.uf = uf;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, f, we, input logic [5:0] wd, input logic re);
    rst = r; flush = f; wclk_en = we; wdata = wd; rclk_en = re;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int cnt, input logic rv,
                               input logic [5:0] rd, input logic of, uf);
    check({tag, " count"}, 32'(count), cnt);
    check({tag, " rvalid"}, 32'(rvalid), 32'(rv));
    check({tag, " rdata"}, 32'(rdata), 32'(rd));
    check({tag, " wfull"}, 32'(wfull), 32'(cnt == 16));
    check({tag, " rempty"}, 32'(rempty), 32'(cnt == 0));
    check({tag, " almost_full"}, 32'(almost_full), 32'(cnt >= 14));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(cnt <= 2));
    check({tag, " overflow"}, 32'(overflow), 32'(of));
    check({tag, " underflow"}, 32'(underflow), 32'(uf));
  endtask

  task automatic model_step(input logic r, f, we, input logic [5:0] wd, input logic re);
    bit full, empty;
    full  = (mq.size() == 16);
    empty = (mq.size() == 0);
    if (r) begin
      mq.delete(); m_rdata = '0; m_rvalid = 1'b0; m_of = 1'b0; m_uf = 1'b0;
    end else if (f) begin
      mq.delete(); m_rvalid = 1'b0; m_of = 1'b0; m_uf = 1'b0;
    end else begin
      if (we && full)  m_of = 1'b1;
      if (re && empty) m_uf = 1'b1;
      m_rvalid = re && !empty;
      if (re && !empty) m_rdata = mq.pop_front();
      if (we && !full)  mq.push_back(wd);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wclk_en = 1'b0; rclk_en = 1'b0; wdata = '0;

    // Reset, fill to full, one overflowing write.
    add(1, 0, 0, 6'h00, 0, 0, 0, 6'h00, 0, 0);
    for (int i = 1; i <= 16; i++)
      add(0, 0, 1, 6'(i), 0, i, 0, 6'h00, 0, 0);
    add(0, 0, 1, 6'h3f, 0, 16, 0, 6'h00, 1, 0);
    // Drain in order, one underflowing read.
    for (int i = 1; i <= 16; i++)
      add(0, 0, 0, 6'h00, 1, 16 - i, 1, 6'(i), 1, 0);
    add(0, 0, 0, 6'h00, 1, 0, 0, 6'h10, 1, 1);
    // Flush with both requests: cleared flags, rdata retained.
    add(0, 1, 1, 6'h2b, 1, 0, 0, 6'h10, 0, 0);
    // Wrap-around: hold count at 3 over 40 read/write pairs.
    for (int i = 1; i <= 3; i++)
      add(0, 0, 1, 6'(i), 0, i, 0, 6'h10, 0, 0);
    for (int k = 0; k < 40; k++)
      add(0, 0, 1, 6'(4 + k), 1, 3, 1, 6'(k + 1), 0, 0);
    // Fill to full, then simultaneous read+write at full.
    for (int i = 0; i < 13; i++)
      add(0, 0, 1, 6'(44 + i), 0, 4 + i, 0, 6'd40, 0, 0);
    add(0, 0, 1, 6'h3e, 1, 15, 1, 6'd41, 1, 0);
    for (int i = 0; i < 15; i++)
      add(0, 0, 0, 6'h00, 1, 14 - i, 1, 6'(42 + i), 1, 0);
    // Simultaneous at empty: write lands, read rejected, no bypass.
    add(0, 0, 1, 6'h2a, 1, 1, 0, 6'd56, 1, 1);
    add(0, 0, 0, 6'h00, 1, 0, 1, 6'h2a, 1, 1);
    // Flush at count 9 with requests pending.
    add(0, 1, 0, 6'h00, 0, 0, 0, 6'h2a, 0, 0);
    for (int i = 1; i <= 9; i++)
      add(0, 0, 1, 6'(i), 0, i, 0, 6'h2a, 0, 0);
    add(0, 1, 1, 6'h33, 1, 0, 0, 6'h2a, 0, 0);
    add(0, 0, 1, 6'h15, 0, 1, 0, 6'h2a, 0, 0);
    add(0, 0, 0, 6'h00, 1, 0, 1, 6'h15, 0, 0);
    // rst mid-burst at count 7 with pending read and write.
    for (int i = 0; i < 7; i++)
      add(0, 0, 1, 6'(32 + i), 0, i + 1, 0, 6'h15, 0, 0);
    add(1, 0, 1, 6'h11, 1, 0, 0, 6'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].wen, vecs[i].wd, vecs[i].ren);
      check_outputs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rv, vecs[i].rd,
                    vecs[i].of, vecs[i].uf);
    end

    // Randomized traffic against the queue model, alternating fill/drain bias.
    model_step(1, 0, 0, 6'h00, 0);
    step(1, 0, 0, 6'h00, 0);
    for (int c = 0; c < 3000; c++) begin
      int   wbias;
      logic r, f, we, re;
      logic [5:0] wd;
      wbias = ((c / 150) % 2 == 0) ? 75 : 25;
      we = ($urandom_range(99) < wbias);
      re = ($urandom_range(99) < (100 - wbias));
      f  = ($urandom_range(199) == 0);
      r  = ($urandom_range(499) == 0);
      wd = 6'($urandom);
      step(r, f, we, wd, re);
      model_step(r, f, we, wd, re);
      check_outputs($sformatf("rand%0d", c), mq.size(), m_rvalid, m_rdata, m_of, m_uf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
